gpreg: RTL and testbench



---
 rtl/gpreg.sv | 41 ++++
 tb/tb_gpreg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpreg.sv
// ============================================================================
// Module   : gpreg
// Brief    : 32 x 8-bit general-purpose register file, two async read ports,
//            one synchronous write port addressed by rA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpreg (
  input  logic [4:0] rA,
  input  logic [4:0] rB,
  input  logic [7:0] data_in,
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  output logic [7:0] outA,
  output logic [7:0] outB
);

  localparam int c_DEPTH = 32;

  logic [7:0] r_regs [0:c_DEPTH-1];

  // Reset dominates a coincident write edge; register 0 is fully writable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (we) begin
      r_regs[rA] <= data_in;
    end
  end

  // Reads are combinational, so a write is only visible after its edge.
  assign outA = r_regs[rA];
  assign outB = r_regs[rB];

endmodule

`default_nettype wire

// File: tb/tb_gpreg.sv
// ============================================================================
// Module   : tb_gpreg
// Brief    : Directed self-checking bench for the gpreg register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpreg;

  logic [4:0] rA;
  logic [4:0] rB;
  logic [7:0] data_in;
  logic       clk;
  logic       reset;
  logic       we;
  logic [7:0] outA;
  logic [7:0] outB;

  int n_cmp;
  int n_err;

  gpreg dut (
    .rA      (rA),
    .rB      (rB),
    .data_in (data_in),
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .outA    (outA),
    .outB    (outB)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Single-cycle write, launched and retired on falling edges.
  task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    rA      = a;
    data_in = d;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
  endtask

  task automatic test_reset();
    rA = 5'd0; rB = 5'd0; we = 1'b0; data_in = 8'h00; reset = 1'b1;
    #50;
    n_cmp++;
    if (outA !== 8'h00 || outB !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held: outA=%h outB=%h expected 00/00", outA, outB);
    end
    #50;
    reset = 1'b0;
    #5;
    for (int i = 0; i < 32; i++) begin
      rA = 5'(i);
      rB = 5'(31 - i);
      #1;
      n_cmp++;
      if (outA !== 8'h00 || outB !== 8'h00) begin
        n_err++;
        $display("FAIL reset_sweep[%0d]: outA=%h outB=%h expected 00/00", i, outA, outB);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 8'hA5);
    rA = 5'd5; rB = 5'd5;
    #1;
    n_cmp++;
    if (outA !== 8'hA5 || outB !== 8'hA5) begin
      n_err++;
      $display("FAIL write_read: outA=%h outB=%h expected A5/A5", outA, outB);
    end
    rB = 5'd6;
    #1;
    n_cmp++;
    if (outB !== 8'h00) begin
      n_err++;
      $display("FAIL neighbour_r6: outB=%h expected 00", outB);
    end
  endtask

  task automatic test_we_gating();
    @(negedge clk);
    we = 1'b0; rA = 5'd7; data_in = 8'h3C;
    repeat (4) @(negedge clk);
    rB = 5'd7;
    #1;
    n_cmp++;
    if (outA !== 8'h00 || outB !== 8'h00) begin
      n_err++;
      $display("FAIL we_gating: outA=%h outB=%h expected 00/00", outA, outB);
    end
  endtask

  task automatic test_dual_port();
    for (int i = 0; i < 32; i++) begin
      write_reg(5'(i), 8'(i + 8'h10));
    end
    rA = 5'd3; rB = 5'd30;
    #1;
    n_cmp++;
    if (outA !== 8'h13 || outB !== 8'h2E) begin
      n_err++;
      $display("FAIL dual_port_3_30: outA=%h outB=%h expected 13/2E", outA, outB);
    end
    rA = 5'd0; rB = 5'd31;
    #1;
    n_cmp++;
    if (outA !== 8'h10 || outB !== 8'h2F) begin
      n_err++;
      $display("FAIL dual_port_0_31: outA=%h outB=%h expected 10/2F", outA, outB);
    end
    rA = 5'd17; rB = 5'd17;
    #1;
    n_cmp++;
    if (outA !== 8'h21 || outB !== 8'h21) begin
      n_err++;
      $display("FAIL same_addr_17: outA=%h outB=%h expected 21/21", outA, outB);
    end
  endtask

  task automatic test_no_bypass();
    write_reg(5'd2, 8'h11);
    @(negedge clk);
    rA = 5'd2; data_in = 8'h22; we = 1'b1;
    #1;
    n_cmp++;
    if (outA !== 8'h11) begin
      n_err++;
      $display("FAIL no_bypass_before: outA=%h expected 11", outA);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (outA !== 8'h22) begin
      n_err++;
      $display("FAIL no_bypass_after: outA=%h expected 22", outA);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we = 1'b1; rA = 5'd10; data_in = 8'hC1;
    @(negedge clk);
    rA = 5'd11; data_in = 8'hC2;
    @(negedge clk);
    rA = 5'd12; data_in = 8'hC3;
    @(negedge clk);
    we = 1'b0; rA = 5'd10; rB = 5'd11;
    #1;
    n_cmp++;
    if (outA !== 8'hC1 || outB !== 8'hC2) begin
      n_err++;
      $display("FAIL b2b_10_11: outA=%h outB=%h expected C1/C2", outA, outB);
    end
    rA = 5'd12; rB = 5'd13;
    #1;
    n_cmp++;
    if (outA !== 8'hC3 || outB !== 8'h1D) begin
      n_err++;
      $display("FAIL b2b_12_13: outA=%h outB=%h expected C3/1D", outA, outB);
    end
  endtask

  task automatic test_async_reset();
    rA = 5'd3; rB = 5'd30;
    @(posedge clk);
    #5;
    n_cmp++;
    if (outA !== 8'h13 || outB !== 8'h2E) begin
      n_err++;
      $display("FAIL pre_reset: outA=%h outB=%h expected 13/2E", outA, outB);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outA !== 8'h00 || outB !== 8'h00 || clk !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_midcycle: outA=%h outB=%h clk=%b expected 00/00 before edge", outA, outB, clk);
    end
    #5;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rA = 5'(i);
      rB = 5'(i ^ 5'h1F);
      #1;
      n_cmp++;
      if (outA !== 8'h00 || outB !== 8'h00) begin
        n_err++;
        $display("FAIL post_reset_sweep[%0d]: outA=%h outB=%h expected 00/00", i, outA, outB);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_we_gating();
    test_dual_port();
    test_no_bypass();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
